hazard_ctrl: RTL

- Backward-direction control block for the 5-stage pipeline. Consumes the ID/EX register outputs, the IF/ID source fields and the MEM-stage status.
- Drives write-enable, flush and freeze controls back into the PC and the IF/ID, ID/EX and EX/MEM registers.
- Handles load-use stalls, branch flushes, multi-cycle memory freezes and halt drain.
- Keeps a stall performance counter.
- Operand forwarding is a separate block and is out of scope here.

---
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Backward pipeline control. Produces PC/IF-ID write enables,
//                IF-ID/ID-EX/EX-MEM flushes and a whole-pipe freeze from
//                load-use hazards, taken branches, multi-cycle memory access
//                and halt drain. Also counts RUN-mode stall cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rs,
    input  logic             ifid_uses_rt,
    input  logic             idex_reg_dst,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       idex_rd,
    input  logic             idex_reg_write,
    input  logic             idex_mem_to_reg,
    input  logic             idex_halt,
    input  logic             mem_busy,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             freeze,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0]       S_RUN        = 2'd0;
    localparam logic [1:0]       S_DRAIN      = 2'd1;
    localparam logic [1:0]       S_HALTED     = 2'd2;
    localparam logic [3:0]       c_drain_init = 4'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max    = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       r_drain_cnt;
    logic [3:0]       w_drain_nxt;
    logic [CNT_W-1:0] r_stall_count;
    logic [4:0]       w_idex_dest;
    logic             w_load_use;

    // Destination of the instruction in EX and whether the IF/ID instruction
    // needs that load result before it can be forwarded.
    always_comb begin
        w_idex_dest = idex_reg_dst ? idex_rd : idex_rt;
        w_load_use  = idex_mem_to_reg & idex_reg_write & (w_idex_dest != 5'd0) &
                      ((ifid_uses_rs & (ifid_rs == w_idex_dest)) |
                       (ifid_uses_rt & (ifid_rt == w_idex_dest)));
    end

    // Control outputs and next-state; reset overrides the outputs last.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        freeze      = 1'b0;
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;

        case (r_state)
            S_RUN: begin
                if (mem_busy) begin
                    // Nothing advances; branch and load-use wait for MEM.
                    freeze     = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                end else if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (w_load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
                // A taken branch squashes the halt sitting in ID/EX.
                if (idex_halt && !mem_busy && !branch_taken) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = c_drain_init;
                end
            end
            S_DRAIN: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                freeze     = mem_busy;
                // Only cycles where the older instructions actually move count.
                if (!mem_busy) begin
                    if (r_drain_cnt <= 4'd1) begin
                        w_state_nxt = S_HALTED;
                        w_drain_nxt = 4'd0;
                    end else begin
                        w_drain_nxt = r_drain_cnt - 4'd1;
                    end
                end
            end
            S_HALTED: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end
            default: begin
                w_state_nxt = S_RUN;
                w_drain_nxt = 4'd0;
            end
        endcase

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            freeze      = 1'b0;
        end
    end

    // State and drain counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_drain_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // Saturating count of RUN cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if ((r_state == S_RUN) && !pc_write && (r_stall_count != c_cnt_max)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign halted      = (r_state == S_HALTED);
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire
